// File: rtl/alu_issue_ctrl.sv
// Issue stage for the 4-bit combinational ALU: command FIFO, registered ALU drive, result capture and response port.
// Optional sticky overflow flag (sticky_clr/sticky_ovf) built only when ALU_ISSUE_STICKY_OVF_EN is defined.
module alu_issue_ctrl #(
   parameter int unsigned DATA_WIDTH = 4,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [2:0]            cmd_op,
   input  logic [DATA_WIDTH-1:0] cmd_a,
   input  logic [DATA_WIDTH-1:0] cmd_b,
   input  logic                  cmd_use_acc,
   output logic [DATA_WIDTH-1:0] alu_ai,
   output logic [DATA_WIDTH-1:0] alu_bi,
   output logic [2:0]            alu_op,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic                  alu_cout,
   input  logic                  alu_overflow,
   input  logic                  alu_zero,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_result,
   output logic [2:0]            rsp_flags,
`ifdef ALU_ISSUE_STICKY_OVF_EN
   input  logic                  sticky_clr,
   output logic                  sticky_ovf,
`endif
   output logic                  busy
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                state, next_state;
   logic [PTR_W-1:0]      wptr, rptr;
   logic [CNT_W-1:0]      count;
   logic [DATA_WIDTH-1:0] acc;
   logic                  push, pop, capture, rsp_done;
   logic                  arith_op;

   logic [2:0]            fifo_op  [DEPTH];
   logic [DATA_WIDTH-1:0] fifo_a   [DEPTH];
   logic [DATA_WIDTH-1:0] fifo_b   [DEPTH];
   logic                  fifo_acc [DEPTH];

   assign cmd_ready = (count != CNT_W'(DEPTH));
   assign push      = cmd_valid && cmd_ready;
   assign busy      = (state != IDLE) || (count != '0);
   // Flags are only meaningful for add/sub.
   assign arith_op  = (alu_op[2:1] == 2'b00);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      pop        = 1'b0;
      capture    = 1'b0;
      rsp_done   = 1'b0;
      case (state)
         IDLE: begin
            if (count != '0) begin
               pop        = 1'b1;
               next_state = EXEC;
            end
         end
         EXEC: begin
            capture    = 1'b1;
            next_state = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_done   = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // FIFO storage carries no reset; occupancy is defined by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_op[wptr]  <= cmd_op;
         fifo_a[wptr]   <= cmd_a;
         fifo_b[wptr]   <= cmd_b;
         fifo_acc[wptr] <= cmd_use_acc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + PTR_W'(1);
         if (pop)  rptr <= rptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_ai     <= '0;
         alu_bi     <= '0;
         alu_op     <= '0;
         acc        <= '0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_flags  <= '0;
      end else begin
         if (pop) begin
            alu_op <= fifo_op[rptr];
            alu_bi <= fifo_b[rptr];
            alu_ai <= fifo_acc[rptr] ? acc : fifo_a[rptr];
         end
         if (capture) begin
            rsp_result <= alu_result;
            rsp_flags  <= arith_op ? {alu_overflow, alu_cout, alu_zero} : 3'b000;
            acc        <= alu_result;
            rsp_valid  <= 1'b1;
         end else if (rsp_done) begin
            rsp_valid  <= 1'b0;
         end
      end
   end

`ifdef ALU_ISSUE_STICKY_OVF_EN
   // Set wins over a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                     sticky_ovf <= 1'b0;
      else if (capture && arith_op && alu_overflow) sticky_ovf <= 1'b1;
      else if (sticky_clr)                         sticky_ovf <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with an attached ALU model and a queue-based response scoreboard.
// Covers the sticky overflow ports when ALU_ISSUE_STICKY_OVF_EN is defined.
module tb_alu_issue_ctrl;

   localparam int unsigned DW    = 4;
   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready, cmd_use_acc;
   logic [2:0]    cmd_op, alu_op;
   logic [DW-1:0] cmd_a, cmd_b, alu_ai, alu_bi, alu_result, rsp_result;
   logic          alu_cout, alu_overflow, alu_zero;
   logic          rsp_valid, rsp_ready, busy;
   logic [2:0]    rsp_flags;
   logic          alu_force;
`ifdef ALU_ISSUE_STICKY_OVF_EN
   logic          sticky_clr, sticky_ovf;
`endif

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   alu_issue_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
      .alu_ai(alu_ai), .alu_bi(alu_bi), .alu_op(alu_op),
      .alu_result(alu_result), .alu_cout(alu_cout),
      .alu_overflow(alu_overflow), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags),
`ifdef ALU_ISSUE_STICKY_OVF_EN
      .sticky_clr(sticky_clr), .sticky_ovf(sticky_ovf),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference ALU: returns {overflow, cout, zero, result}.
   function automatic logic [DW+2:0] alu_f(input logic [2:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
      logic [DW:0]   s;
      logic [DW-1:0] r;
      logic          c, v;
      s = '0; c = 1'b0; v = 1'b0;
      case (op)
         3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[DW-1:0]; c = s[DW];
                     v = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]); end
         3'd1: begin s = {1'b0, a} + {1'b0, ~b} + (DW+1)'(1); r = s[DW-1:0]; c = s[DW];
                     v = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]); end
         3'd2: r = ~a;
         3'd3: r = a & b;
         3'd4: r = a | b;
         3'd5: r = a ^ b;
         3'd6: r = DW'(a < b);
         default: r = DW'(a == b);
      endcase
      return {v, c, (r == '0), r};
   endfunction

   always_comb begin
      logic [DW+2:0] f;
      f            = alu_f(alu_op, alu_ai, alu_bi);
      alu_result   = f[DW-1:0];
      alu_zero     = f[DW]   | alu_force;
      alu_cout     = f[DW+1] | alu_force;
      alu_overflow = f[DW+2] | alu_force;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Scoreboard: expected responses computed in push order with a model accumulator.
   logic [DW+2:0] exp_q[$];
   int            hs_cyc[$];
   logic [DW-1:0] acc_m = '0;

   always @(negedge clk) begin
      logic [DW+2:0] f;
      cyc++;
      if (rst) begin
         exp_q.delete();
         acc_m = '0;
      end else begin
         if (cmd_valid && cmd_ready) begin
            f     = alu_f(cmd_op, cmd_use_acc ? acc_m : cmd_a, cmd_b);
            acc_m = f[DW-1:0];
            exp_q.push_back({(cmd_op <= 3'd1) ? f[DW+2:DW] : 3'b000, f[DW-1:0]});
         end
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
               check("sb_result", 32'(rsp_result), 32'(exp_q[0][DW-1:0]));
               check("sb_flags",  32'(rsp_flags),  32'(exp_q[0][DW+2:DW]));
               if (rsp_ready) begin
                  void'(exp_q.pop_front());
                  hs_cyc.push_back(cyc);
               end
            end
         end
      end
   end

   task automatic set_cmd(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic ua);
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua;
   endtask

   // One-cycle push; returns 1ns after the push edge.
   task automatic push(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic ua);
      @(posedge clk); #1;
      set_cmd(op, a, b, ua);
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string name);
      int n = 0;
      while (!rsp_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!rsp_valid) check(name, 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]    ops [5] = '{3'd0, 3'd1, 3'd4, 3'd6, 3'd0};
      logic [DW-1:0] as  [5] = '{4'd1, 4'd2, 4'd5, 4'd3, 4'd0};
      logic [DW-1:0] bs  [5] = '{4'd1, 4'd5, 4'd2, 4'd9, 4'd6};
      logic          uas [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic          seen;
      int            n;

      rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1; alu_force = 1'b0;
      set_cmd(3'd0, '0, '0, 1'b0);
`ifdef ALU_ISSUE_STICKY_OVF_EN
      sticky_clr = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_alu", 32'({alu_ai, alu_bi, alu_op}), 32'd0);
      check("rst_rsp_data", 32'({rsp_result, rsp_flags}), 32'd0);
      rst = 1'b0;

      // Basic add with latency checks
      push(3'd0, 4'd3, 4'd4, 1'b0);
      @(posedge clk); #1;
      check("issue_ai", 32'(alu_ai), 32'd3);
      check("issue_bi", 32'(alu_bi), 32'd4);
      check("issue_op", 32'(alu_op), 32'd0);
      check("issue_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
      check("lat_valid", 32'(rsp_valid), 32'd1);
      check("add_result", 32'(rsp_result), 32'd7);
      check("add_flags", 32'(rsp_flags), 32'd0);

      // Overflow, then chained subtract through the accumulator
      push(3'd0, 4'd7, 4'd1, 1'b0);
      wait_rsp("ovf_timeout");
      check("ovf_result", 32'(rsp_result), 32'd8);
      check("ovf_flags", 32'(rsp_flags), 32'b100);
      push(3'd1, 4'd5, 4'd8, 1'b1);
      @(posedge clk); #1;
      check("acc_ai", 32'(alu_ai), 32'd8);
      wait_rsp("sub_timeout");
      check("sub_result", 32'(rsp_result), 32'd0);
      check("sub_flags", 32'(rsp_flags), 32'b011);

      // Logic op: flags masked even with ALU flags forced high
      alu_force = 1'b1;
      push(3'd3, 4'hC, 4'hA, 1'b0);
      wait_rsp("and_timeout");
      check("and_result", 32'(rsp_result), 32'h8);
      check("and_flags", 32'(rsp_flags), 32'd0);
      alu_force = 1'b0;
      @(posedge clk); #1;

      // Backpressure: fill FIFO behind a held response
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_cmd(ops[i], as[i], bs[i], uas[i]);
         cmd_valid = 1'b1;
         @(posedge clk); #1;
      end
      check("full_ready", 32'(cmd_ready), 32'd0);
      set_cmd(3'd0, 4'hF, 4'hF, 1'b0);
      @(posedge clk); #1;
      check("refused_ready", 32'(cmd_ready), 32'd0);
      cmd_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("held_valid", 32'(rsp_valid), 32'd1);
      check("held_result", 32'(rsp_result), 32'd2);
      hs_cyc.delete();
      rsp_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      check("drain_count", 32'(hs_cyc.size()), 32'd5);
      for (int i = 1; i < hs_cyc.size(); i++)
         check("rsp_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd3);
      @(posedge clk); #1;
      check("drain_busy", 32'(busy), 32'd0);

      // Reset while in EXEC with two commands queued
      rsp_ready = 1'b0;
      push(3'd0, 4'd1, 4'd2, 1'b0);
      wait_rsp("pre_rst_timeout");
      for (int i = 1; i <= 3; i++) begin
         set_cmd(3'd0, DW'(i), DW'(i), 1'b0);
         cmd_valid = 1'b1;
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("exec_ai", 32'(alu_ai), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("mid_rst_rsp", 32'({rsp_valid, rsp_result, rsp_flags}), 32'd0);
      check("mid_rst_alu", 32'({alu_ai, alu_bi, alu_op}), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         seen |= rsp_valid | busy;
      end
      check("no_rsp_after_rst", 32'(seen), 32'd0);

      // Accumulator cleared by reset
      push(3'd0, 4'd9, 4'd3, 1'b1);
      wait_rsp("acc0_timeout");
      check("acc_reset_result", 32'(rsp_result), 32'd3);

`ifdef ALU_ISSUE_STICKY_OVF_EN
      @(posedge clk); #1;
      check("sticky_init", 32'(sticky_ovf), 32'd0);
      push(3'd0, 4'd7, 4'd1, 1'b0);
      wait_rsp("sticky1_timeout");
      check("sticky_set", 32'(sticky_ovf), 32'd1);
      push(3'd0, 4'd1, 4'd1, 1'b0);
      wait_rsp("sticky2_timeout");
      check("sticky_hold", 32'(sticky_ovf), 32'd1);
      sticky_clr = 1'b1;
      @(posedge clk); #1;
      sticky_clr = 1'b0;
      check("sticky_clr", 32'(sticky_ovf), 32'd0);
`endif

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Upstream issue stage for the combinational 4-bit ALU (op encoding 000 add, 001 sub, 010 not, 011 and, 100 or, 101 xor, 110 less-than, 111 equal).
- Buffers operation commands in a small FIFO and drives registered operands and opcode into the ALU.
- Captures the ALU result and flags one cycle after issue, then returns them over a valid/ready response port.
- Holds an accumulator (the last captured result); a command can select it as operand A, which allows chained operations.

Parameters:
- DATA_WIDTH, 4: operand/result width; must match the ALU.
- DEPTH, 4: command FIFO entries; power of 2, ≥2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !full, taken from registered count.
- cmd_op  in  3  ALU opcode.
- cmd_a  in  DATA_WIDTH  operand A.
- cmd_b  in  DATA_WIDTH  operand B.
- cmd_use_acc  in  1  1: operand A is the accumulator and cmd_a is ignored.
- alu_ai  out  DATA_WIDTH  registered operand A to the ALU.
- alu_bi  out  DATA_WIDTH  registered operand B to the ALU.
- alu_op  out  3  registered opcode to the ALU.
- alu_result  in  DATA_WIDTH  ALU Result.
- alu_cout  in  1  ALU Cout.
- alu_overflow  in  1  ALU Overflow.
- alu_zero  in  1  ALU Zero.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer accepts.
- rsp_result  out  DATA_WIDTH  captured result.
- rsp_flags  out  3  captured flags as {overflow, cout, zero}.
- busy  out  1  FSM not IDLE, or FIFO not empty.

Behaviour:
- Reset: while rst is high and immediately after, the following hold.
  - FIFO empty and pointers 0; cmd_ready=1.
  - FSM=IDLE; accumulator=0.
  - alu_ai, alu_bi and alu_op = 0.
  - rsp_valid=0, rsp_result=0, rsp_flags=0, busy=0.
- Reset mid-operation: any in-flight command, queued commands and the held response are discarded. No response is emitted for them.
- Push: cmd_valid && cmd_ready at an edge writes {op, a, b, use_acc} to FIFO[wptr]. The write pointer wraps modulo DEPTH.
- Push when full: cmd_ready=0, so no write occurs; FIFO contents are unchanged.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head at the edge. Load alu_op and alu_bi. Load alu_ai from the accumulator if use_acc, else from cmd_a. Go to EXEC. If the FIFO is empty, stay in IDLE.
  - EXEC: exactly one cycle.
    - At the edge, capture rsp_result = alu_result.
    - If alu_op is 000 or 001, rsp_flags = {alu_overflow, alu_cout, alu_zero}; otherwise rsp_flags = 000.
    - accumulator = alu_result.
    - rsp_valid becomes 1; go to RESP.
  - RESP: rsp_valid=1; rsp_result and rsp_flags stay stable until accepted.
    - On rsp_valid && rsp_ready at the edge: rsp_valid becomes 0 and the FSM goes to IDLE.
    - alu_ai, alu_bi and alu_op keep their last values.
- Latency: a command pushed at edge T into an empty FIFO with the FSM in IDLE is popped at T+1. rsp_valid is high after edge T+2.
- Minimum spacing: one response per 3 cycles when rsp_ready is held high.
- Simultaneous push and pop in IDLE: both occur and the count is unchanged. When the FIFO is full, a pop in the same cycle does not raise cmd_ready; cmd_ready is based on the registered count.
- Accumulator ordering: a command with use_acc sees the result of the immediately preceding command, because commands issue in order and one at a time.
- Widths: the FIFO count is clog2(DEPTH)+1 bits. The accumulator is DATA_WIDTH bits and is not extended.

Optional Feature:
- Macro: ALU_ISSUE_STICKY_OVF_EN.
- When defined: adds ports sticky_clr (in, 1) and sticky_ovf (out, 1).
  - sticky_ovf resets to 0.
  - It is set at the EXEC edge when the op is 000/001 and alu_overflow=1.
  - It is cleared when sticky_clr=1 at an edge, unless a set occurs at the same edge; set wins.
- When not defined: neither port exists and no sticky register is built.

Test Plan:
- Reset, then push op=000, a=3, b=4, ALU model attached → alu_ai=3, alu_bi=4, alu_op=000 after T+1; after T+2 rsp_valid=1, rsp_result=7, rsp_flags=000.
- op=000, a=7, b=1 → rsp_result=8, rsp_flags={1,0,0}. Then op=001, use_acc=1, b=8 → alu_ai=8, rsp_result=0, zero flag=1.
- op=011, a=0xC, b=0xA → rsp_result=0x8, rsp_flags=000 regardless of the ALU flag inputs.
- Hold rsp_ready=0 and push 5 commands → cmd_ready drops after 4 are queued plus 1 has issued, the 6th push is refused, and the response is held stable. Then release rsp_ready → all responses arrive in order with 3-cycle spacing.
- Assert rst while in EXEC with 2 commands queued → all outputs return to reset values; no rsp_valid afterwards; busy=0.
- With ALU_ISSUE_STICKY_OVF_EN: op=000, a=7, b=1 → sticky_ovf=1 and stays 1 through a later op=000, a=1, b=1. Pulse sticky_clr → sticky_ovf=0.
